// File: rtl/secuenciador_primos_pares.sv
// Scan controller: steps a 4-bit code LO..HI (mod 16) into the prime/even classifier and tallies its flags.
// Latency: SETTLE+1 cycles per code; DONE pulses N*(SETTLE+1) cycles after the accepting START edge.
// Backpressure: none; START is taken only in IDLE, ABORT drops the scan and keeps partial results.
module secuenciador_primos_pares #(
  parameter int SETTLE = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [3:0]  LO,
  input  logic [3:0]  HI,
  input  logic        PRIMOS,
  input  logic        PARES,
  output logic        D,
  output logic        C,
  output logic        B,
  output logic        A,
  output logic        BUSY,
  output logic        DONE,
  output logic [4:0]  N_PRIMOS,
  output logic [4:0]  N_PARES,
  output logic [15:0] MASK_PRIMOS,
  output logic [15:0] MASK_PARES
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [2:0] SETTLE_W = 3'(SETTLE);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] code;
  logic [3:0] hi_r;
  logic [2:0] sc;
  logic       sample_en;
  logic       last_code;

  // A sample only lands if the scan is not being aborted in the same cycle.
  assign sample_en = (state == SCAN) && (sc == SETTLE_W) && !ABORT;
  assign last_code = (code == hi_r);

  // The code register drives the classifier directly, so D..A are registered.
  assign D = code[3];
  assign C = code[2];
  assign B = code[1];
  assign A = code[0];

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: ABORT beats a completing sample; START beats ABORT in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (sample_en && last_code) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      SCAN:    BUSY = 1'b1;
      FIN:     DONE = 1'b1;
      default: begin
        BUSY = 1'b0;
        DONE = 1'b0;
      end
    endcase
  end

  // Datapath: code stepping, settle counter, and result accumulation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code        <= 4'd0;
      hi_r        <= 4'd0;
      sc          <= 3'd0;
      N_PRIMOS    <= 5'd0;
      N_PARES     <= 5'd0;
      MASK_PRIMOS <= 16'd0;
      MASK_PARES  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            code        <= LO;
            hi_r        <= HI;
            sc          <= 3'd0;
            N_PRIMOS    <= 5'd0;
            N_PARES     <= 5'd0;
            MASK_PRIMOS <= 16'd0;
            MASK_PARES  <= 16'd0;
          end
        end
        SCAN: begin
          if (!ABORT) begin
            if (sc != SETTLE_W) begin
              sc <= sc + 3'd1;
            end else begin
              N_PRIMOS          <= N_PRIMOS + 5'(PRIMOS);
              N_PARES           <= N_PARES + 5'(PARES);
              MASK_PRIMOS[code] <= PRIMOS;
              MASK_PARES[code]  <= PARES;
              // On the last code, hold it so it stays visible through FIN.
              if (!last_code) begin
                code <= code + 4'd1;
                sc   <= 3'd0;
              end
            end
          end
        end
        default: begin
          code <= code;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_primos_pares.sv
module tb_secuenciador_primos_pares;

  typedef struct {
    logic [4:0]  np;
    logic [4:0]  ne;
    logic [15:0] mp;
    logic [15:0] me;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  abort;
  logic [3:0]  lo;
  logic [3:0]  hi;

  logic [3:0]  code0, code1;
  logic        busy0, busy1, done0, done1;
  logic [4:0]  np0, np1, ne0, ne1;
  logic [15:0] mp0, mp1, me0, me1;
  logic        pr0, pa0, pr1, pa1;

  bit          sel;
  logic [3:0]  obs_code;
  logic        obs_busy, obs_done;
  logic [4:0]  obs_np, obs_ne;
  logic [15:0] obs_mp, obs_me;

  res_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  // Golden classifier (combinational on each DUT's code).
  function automatic logic is_prime(input logic [3:0] c);
    case (c)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign pr0 = is_prime(code0);
  assign pa0 = ~code0[0];
  assign pr1 = is_prime(code1);
  assign pa1 = ~code1[0];

  secuenciador_primos_pares #(.SETTLE(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .ABORT(abort[0]),
    .LO(lo), .HI(hi), .PRIMOS(pr0), .PARES(pa0),
    .D(code0[3]), .C(code0[2]), .B(code0[1]), .A(code0[0]),
    .BUSY(busy0), .DONE(done0), .N_PRIMOS(np0), .N_PARES(ne0),
    .MASK_PRIMOS(mp0), .MASK_PARES(me0)
  );

  secuenciador_primos_pares #(.SETTLE(3)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .ABORT(abort[1]),
    .LO(lo), .HI(hi), .PRIMOS(pr1), .PARES(pa1),
    .D(code1[3]), .C(code1[2]), .B(code1[1]), .A(code1[0]),
    .BUSY(busy1), .DONE(done1), .N_PRIMOS(np1), .N_PARES(ne1),
    .MASK_PRIMOS(mp1), .MASK_PARES(me1)
  );

  always_comb begin
    obs_code = sel ? code1 : code0;
    obs_busy = sel ? busy1 : busy0;
    obs_done = sel ? done1 : done0;
    obs_np   = sel ? np1   : np0;
    obs_ne   = sel ? ne1   : ne0;
    obs_mp   = sel ? mp1   : mp0;
    obs_me   = sel ? me1   : me0;
  end

  // Expected results for n codes starting at first, pushed when stimulus is driven.
  task automatic model_push(input logic [3:0] first, input int n);
    res_t r;
    logic [3:0] c;
    r.np = '0; r.ne = '0; r.mp = '0; r.me = '0;
    for (int k = 0; k < n; k++) begin
      c = first + 4'(k);
      if (is_prime(c)) begin
        r.np = r.np + 5'd1;
        r.mp[c] = 1'b1;
      end
      if (c[0] == 1'b0) begin
        r.ne = r.ne + 5'd1;
        r.me[c] = 1'b1;
      end
    end
    sb.push_back(r);
  endtask

  // Runs one complete scan on the selected instance, checking code timing,
  // DONE timing and the scoreboarded results; returns what the DUT reported.
  task automatic run_scan(input bit s, input logic [3:0] l, input logic [3:0] h,
                          output res_t got);
    int per;
    int n;
    int cyc;
    bit seen;
    logic [3:0] diff;
    logic [3:0] ec;
    res_t e;
    per  = s ? 4 : 1;
    diff = h - l;
    n    = int'(diff) + 1;
    sel  = s;
    lo   = l;
    hi   = h;
    start[s] = 1'b1;
    model_push(l, n);
    @(posedge clk); #1;
    start[s] = 1'b0;
    checks++;
    if ({obs_busy, obs_done, obs_code} !== {1'b1, 1'b0, l})
      $display("FAIL scan_start: busy/done/code got %b/%b/%h expected 1/0/%h", obs_busy, obs_done, obs_code, l);
    if ({obs_busy, obs_done, obs_code} !== {1'b1, 1'b0, l}) fails++;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < n * per + 10) begin
      @(posedge clk); #1;
      cyc++;
      if (obs_done) begin
        seen = 1'b1;
      end else begin
        ec = l + 4'(cyc / per);
        checks++;
        if ({obs_busy, obs_code} !== {1'b1, ec}) begin
          fails++;
          $display("FAIL scan_code: cycle %0d busy/code got %b/%h expected 1/%h", cyc, obs_busy, obs_code, ec);
        end
      end
    end
    got.np = obs_np; got.ne = obs_ne; got.mp = obs_mp; got.me = obs_me;
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL scan_timeout: no DONE within %0d cycles", n * per + 10);
      void'(sb.pop_front());
    end else begin
      if (cyc != n * per || obs_busy !== 1'b0) begin
        fails++;
        $display("FAIL done_timing: DONE at t0+%0d busy %b expected t0+%0d busy 0", cyc, obs_busy, n * per);
      end
      e = sb.pop_front();
      checks++;
      if (obs_np !== e.np || obs_ne !== e.ne) begin
        fails++;
        $display("FAIL counts: got primos %0d pares %0d expected %0d %0d", obs_np, obs_ne, e.np, e.ne);
      end
      checks++;
      if (obs_mp !== e.mp || obs_me !== e.me) begin
        fails++;
        $display("FAIL masks: got primos %h pares %h expected %h %h", obs_mp, obs_me, e.mp, e.me);
      end
      @(posedge clk); #1;
      checks++;
      if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse: after DONE cycle done/busy got %b/%b expected 0/0", obs_done, obs_busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = '0; abort = '0; lo = '0; hi = '0; sel = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, code0, np0, ne0, mp0, me0, busy1, done1, code1, np1, ne1, mp1, me1} !== '0) begin
      fails++;
      $display("FAIL reset_state: dut0 %b%b %h %0d %0d %h %h dut1 %b%b %h %0d %0d %h %h expected all 0",
               busy0, done0, code0, np0, ne0, mp0, me0, busy1, done1, code1, np1, ne1, mp1, me1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_idle: busy/done got %b%b %b%b expected 00 00", busy0, done0, busy1, done1);
    end
  endtask

  task automatic test_full_scan();
    res_t g;
    run_scan(1'b0, 4'd0, 4'd15, g);
    checks++;
    if (g.np !== 5'd6 || g.ne !== 5'd8 || g.mp !== 16'h28AC || g.me !== 16'h5555) begin
      fails++;
      $display("FAIL full_scan_golden: got %0d %0d %h %h expected 6 8 28ac 5555", g.np, g.ne, g.mp, g.me);
    end
  endtask

  task automatic test_settle();
    res_t g;
    run_scan(1'b1, 4'd2, 4'd5, g);
    checks++;
    if (g.np !== 5'd3 || g.ne !== 5'd2 || g.mp !== 16'h002C) begin
      fails++;
      $display("FAIL settle_golden: got %0d %0d %h expected 3 2 002c", g.np, g.ne, g.mp);
    end
  endtask

  task automatic test_wrap();
    res_t g;
    run_scan(1'b0, 4'd13, 4'd2, g);
    checks++;
    if (g.np !== 5'd2 || g.ne !== 5'd3 || g.me !== 16'h4005) begin
      fails++;
      $display("FAIL wrap_golden: got %0d %0d %h expected 2 3 4005", g.np, g.ne, g.me);
    end
  endtask

  task automatic test_single();
    res_t g;
    run_scan(1'b0, 4'd7, 4'd7, g);
    checks++;
    if (g.np !== 5'd1 || g.ne !== 5'd0 || g.mp !== 16'h0080) begin
      fails++;
      $display("FAIL single_golden: got %0d %0d %h expected 1 0 0080", g.np, g.ne, g.mp);
    end
  endtask

  task automatic test_abort();
    res_t e;
    sel = 1'b0; lo = 4'd0; hi = 4'd15;
    start[0] = 1'b1;
    model_push(4'd0, 5);
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      start[0] = (j == 2);
      checks++;
      if ({busy0, code0} !== {1'b1, 4'(j)}) begin
        fails++;
        $display("FAIL abort_run: t0+%0d busy/code got %b/%h expected 1/%h", j, busy0, code0, 4'(j));
      end
    end
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      fails++;
      $display("FAIL abort_exit: busy/done got %b/%b expected 0/0", busy0, done0);
    end
    e = sb.pop_front();
    checks++;
    if (np0 !== e.np || ne0 !== e.ne || mp0 !== e.mp || me0 !== e.me || me0 !== 16'h0015) begin
      fails++;
      $display("FAIL abort_partial: got %0d %0d %h %h expected %0d %0d %h %h",
               np0, ne0, mp0, me0, e.np, e.ne, e.mp, e.me);
    end
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || me0 !== e.me) begin
        fails++;
        $display("FAIL abort_hold: done/busy/mask got %b/%b/%h expected 0/0/%h", done0, busy0, me0, e.me);
      end
    end
  endtask

  task automatic test_idle_controls();
    // ABORT alone in IDLE does nothing; START with ABORT in IDLE starts.
    abort[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || me0 !== 16'h0015) begin
      fails++;
      $display("FAIL idle_abort: busy/mask got %b/%h expected 0/0015", busy0, me0);
    end
    lo = 4'd9; hi = 4'd12;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    abort[0] = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || code0 !== 4'd9 || me0 !== 16'h0000) begin
      fails++;
      $display("FAIL start_wins: busy/code/mask got %b/%h/%h expected 1/9/0000", busy0, code0, me0);
    end
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      fails++;
      $display("FAIL abort_first_code: busy/done got %b/%b expected 0/0", busy0, done0);
    end
  endtask

  task automatic test_back_to_back();
    res_t g;
    run_scan(1'b1, 4'd0, 4'd15, g);
    run_scan(1'b1, 4'd15, 4'd0, g);
    checks++;
    if (g.np !== 5'd0 || g.ne !== 5'd1 || g.me !== 16'h0001) begin
      fails++;
      $display("FAIL b2b_golden: got %0d %0d %h expected 0 1 0001", g.np, g.ne, g.me);
    end
  endtask

  task automatic test_reset_mid_scan();
    sel = 1'b0; lo = 4'd0; hi = 4'd15;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, code0, np0, ne0, mp0, me0} !== '0) begin
      fails++;
      $display("FAIL reset_mid_scan: %b %b %h %0d %0d %h %h expected all 0", busy0, done0, code0, np0, ne0, mp0, me0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_done: busy/done got %b/%b expected 0/0", busy0, done0);
      end
    end
    test_full_scan();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_settle();
    test_wrap();
    test_single();
    test_abort();
    test_idle_controls();
    test_back_to_back();
    test_reset_mid_scan();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
